// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: DrawX/DrawY counters on a pixel enable, sync and
// blank levels registered together with the counters, and line/frame strobes.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    // 11-bit bounds so a window ending exactly at 1024 still compares correctly.
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic       ls_q, ls_d, fs_q, fs_d;
    logic [7:0] fcnt_q, fcnt_d;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        fcnt_d  = fcnt_q;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d  = '0;
                ls_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d    = '0;
                    fs_d   = 1'b1;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
            // Levels come from the next position so they line up with DrawX/DrawY.
            hs_d    = !(({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END));
            vs_d    = !(({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END));
            blank_d = ({1'b0, x_d} < H_VIS) && ({1'b0, y_d} < V_VIS);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fcnt_q  <= 8'hFF;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a tiny
// 8x4 instance share stimulus; expectations come from an enabled-edge count.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic       d_hs, d_vs, d_blank, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_blank, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en),
        .hs(d_hs), .vs(d_vs), .blank(d_blank), .DrawX(d_x), .DrawY(d_y),
        .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en),
        .hs(s_hs), .vs(s_vs), .blank(s_blank), .DrawX(s_x), .DrawY(s_y),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    int checks = 0;
    int failures = 0;
    int n_en = 0;          // enabled edges since the last reset
    int small_wraps = 0;   // frame_cnt 255->0 wraps seen on the small instance
    obs_t sb_d[$];
    obs_t sb_s[$];

    // Position is just the (n-1)th pixel of an endless raster; n=0 is the reset state.
    function automatic obs_t model(input int n, input bit en_edge,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb);
        obs_t e;
        int ht, vt, p, x, y;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (n == 0) begin
            e.x = 10'(ht - 1); e.y = 10'(vt - 1);
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
            e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'hFF;
        end else begin
            p = n - 1;
            x = p % ht;
            y = (p / ht) % vt;
            e.x = 10'(x);
            e.y = 10'(y);
            e.fc = 8'((p / (ht * vt)) % 256);
            e.hs = !(x >= hv + hf && x < hv + hf + hsw);
            e.vs = !(y >= vv + vf && y < vv + vf + vsw);
            e.blank = (x < hv) && (y < vv);
            e.ls = en_edge && (x == 0);
            e.fs = en_edge && (x == 0) && (y == 0);
        end
        return e;
    endfunction

    task automatic step(input bit r, input bit en);
        bit en_edge;
        @(negedge clk);
        reset = r;
        pix_en = en;
        en_edge = !r && en;
        if (r) n_en = 0;
        else if (en) n_en++;
        sb_d.push_back(model(n_en, en_edge, 640, 16, 96, 48, 480, 10, 2, 33));
        sb_s.push_back(model(n_en, en_edge, 8, 1, 2, 1, 4, 1, 2, 1));
    endtask

    // Monitor: every clock the DUTs present a new output set.
    initial begin
        obs_t exp_v, got;
        logic [7:0] prev_sfc;
        prev_sfc = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (sb_d.size() > 0) begin
                exp_v = sb_d.pop_front();
                got = '{d_hs, d_vs, d_blank, d_x, d_y, d_ls, d_fs, d_fc};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL default_out got hs=%b vs=%b bl=%b x=%0d y=%0d ls=%b fs=%b fc=%0d need hs=%b vs=%b bl=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                             got.hs, got.vs, got.blank, got.x, got.y, got.ls, got.fs, got.fc,
                             exp_v.hs, exp_v.vs, exp_v.blank, exp_v.x, exp_v.y, exp_v.ls, exp_v.fs, exp_v.fc);
                end
            end
            if (sb_s.size() > 0) begin
                exp_v = sb_s.pop_front();
                got = '{s_hs, s_vs, s_blank, s_x, s_y, s_ls, s_fs, s_fc};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL small_out got hs=%b vs=%b bl=%b x=%0d y=%0d ls=%b fs=%b fc=%0d need hs=%b vs=%b bl=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                             got.hs, got.vs, got.blank, got.x, got.y, got.ls, got.fs, got.fc,
                             exp_v.hs, exp_v.vs, exp_v.blank, exp_v.x, exp_v.y, exp_v.ls, exp_v.fs, exp_v.fc);
                end
                if (prev_sfc == 8'hFF && s_fc == 8'h00 && !reset) small_wraps++;
                prev_sfc = s_fc;
            end
        end
    end

    initial begin
        // Reset held with pix_en both low and high.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        // Free run into line 5, DrawX=700 (inside the hsync pulse).
        while (n_en < 5 * 800 + 701) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        // pix_en alternating: half-rate advance, strobes still one clock wide.
        for (int i = 0; i < 2000; i++) step(1'b0, i[0]);
        // Long randomized run; enough enabled edges for the small frame_cnt to wrap.
        for (int i = 0; i < 36000; i++) step(1'b0, $urandom_range(0, 3) != 0);
        @(posedge clk);
        #2;
        checks++;
        if (sb_d.size() != 0 || sb_s.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d/%0d pending need 0/0", sb_d.size(), sb_s.size());
        end
        checks++;
        if (small_wraps < 1) begin
            failures++;
            $display("FAIL small_frame_cnt_wrap got %0d wraps need >=1", small_wraps);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: sync pulses plus the DrawX/DrawY/blank stream consumed by sprite and text renderers.
- Produces 640x480 at 60 Hz by default, with the pixel counters advancing on a pixel-clock enable.
- Supplies per-frame and per-line strobes and a frame counter for game-logic and animation timing.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BACK, 33, vertical back porch, in lines
- Derived, not overridable: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).

Ports:
- vga_clk  in  1  pixel/system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel advance enable; tie to 1 when vga_clk is the 25 MHz pixel clock
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = visible region (renderers drive colour only when blank=1), 0 = blanking
- DrawX  out  10  current horizontal counter value
- DrawY  out  10  current vertical counter value
- line_start  out  1  one-cycle strobe on entry to DrawX=0
- frame_start  out  1  one-cycle strobe on entry to DrawX=0, DrawY=0
- frame_cnt  out  8  frames started since reset, mod 256

Behaviour:
- Interface: one clock (vga_clk); reset is synchronous and active-high.
- Reset values, held while reset=1 regardless of pix_en:
  - DrawX = H_TOTAL-1 (799), DrawY = V_TOTAL-1 (524)
  - hs = 1, vs = 1, blank = 0
  - line_start = 0, frame_start = 0
  - frame_cnt = 8'hFF
- Counter advance, on posedge with reset=0 and pix_en=1:
  - DrawX increments.
  - When DrawX = H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - When DrawY = V_TOTAL-1 at that wrap, DrawY wraps to 0.
- Effect of reset release: the first enabled edge after reset lands on (0,0), so the first post-reset frame is complete.
- With pix_en=0, all counters and levels (hs, vs, blank, frame_cnt) hold.
- hs, vs and blank are registered, computed from the next counter values, so they always align with the DrawX/DrawY on the same cycle. There is no pipeline offset between position and sync/blank.
  - hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491). vs is a function of DrawY only and changes at the line wrap.
  - blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Strobes:
  - line_start = 1 for exactly one vga_clk cycle, the cycle after an enabled edge that wrapped DrawX to 0.
  - It is cleared on the next vga_clk edge even if pix_en=0.
  - frame_start is the same, but only when both counters wrapped to 0. frame_start implies line_start.
- frame_cnt increments, with natural wrap 255 -> 0, on the same edge that raises frame_start. The first frame after reset is therefore frame 0.
- Reset asserted mid-line or mid-frame: the next edge returns every output to its reset value, with no partial strobe.
- Width rules:
  - Counters are 10 bits. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; compile-time check required.
  - Comparisons are unsigned.

Test Plan:
- Reset, then hold reset=0 and pix_en=1 for 1 cycle -> DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1, line_start=1, frame_cnt=0. On the following cycle, frame_start=0 and DrawX=1.
- Run one full line -> blank falls when DrawX=640; hs=0 for exactly 96 cycles, DrawX 656..751; wrap 799->0 with DrawY 0->1 and a single line_start pulse.
- Run 3 full frames with a checker -> 525 lines/frame; vs low exactly on lines 490-491 (1600 cycles); blank=1 count = 307200/frame; frame_cnt reaches 2 on the third frame_start; exactly 420000 cycles between frame_start pulses.
- pix_en toggling every other cycle -> same sequence at half rate; each strobe is exactly 1 vga_clk wide; counters frozen on pix_en=0 cycles.
- Assert reset at DrawX=700 (during hs low) on line 300 -> the next cycle shows all reset values (hs=1, DrawX=799, DrawY=524, frame_cnt=FF); after release, frame restarts at (0,0).
- Override parameters to an 8x4 visible region (front porch 1, sync 2, back porch 1, both axes) -> H_TOTAL=12, V_TOTAL=8; hs low at DrawX 9..10; vs low at DrawY 5..6; frame_start every 96 enabled cycles.
